// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the multi-cycle ALU and the
// decoder that produces aluControl.
package alu_pkg;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSll = 3'b100;
   localparam logic [2:0] AluSlt = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StDone
   } state_e;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU datapath: add, sub, and, or, signed slt.
// Every other code, including the shift code, produces 0.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2:0]       ctrl_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o
);

   always_comb begin
      result_o = '0;
      case (ctrl_i)
         AluAdd:  result_o = a_i + b_i;
         AluSub:  result_o = a_i - b_i;
         AluAnd:  result_o = a_i & b_i;
         AluOr:   result_o = a_i | b_i;
         AluSlt:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: IDLE/EXEC/DONE handshake around alu_core with registered result.
// Define ALU_SERIAL_SHIFT_EN to add a one-bit-per-cycle logical left shift on code 100.
module alu_multiciclo
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       aluControl,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] aluResult,
   output logic             zero
);

   state_e           state_q, state_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] core_result;
   logic [WIDTH-1:0] exec_res;
   logic             exec_last;

`ifdef ALU_SERIAL_SHIFT_EN
   localparam int unsigned ShW = $clog2(WIDTH);
   logic [ShW-1:0] cnt_q, cnt_d;
`endif

   alu_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .ctrl_i  (ctrl_q),
      .a_i     (a_q),
      .b_i     (b_q),
      .result_o(core_result)
   );

   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      zero_d    = zero_q;
      exec_res  = core_result;
      exec_last = 1'b1;
`ifdef ALU_SERIAL_SHIFT_EN
      cnt_d = cnt_q;
      // a_q doubles as the shift register; the final shift folds into the DONE write.
      if (ctrl_q == AluSll) begin
         exec_res  = (cnt_q == '0) ? a_q : (a_q << 1);
         exec_last = (cnt_q <= ShW'(1));
      end
`endif

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StExec;
               ctrl_d  = aluControl;
               a_d     = srcA;
               b_d     = srcB;
`ifdef ALU_SERIAL_SHIFT_EN
               cnt_d   = srcB[ShW-1:0];
`endif
            end else begin
               state_d = StIdle;
            end
         end
         StExec: begin
            if (exec_last) begin
               state_d  = StDone;
               result_d = exec_res;
               zero_d   = (exec_res == '0);
            end else begin
`ifdef ALU_SERIAL_SHIFT_EN
               a_d   = a_q << 1;
               cnt_d = cnt_q - 1'b1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         ctrl_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
`ifdef ALU_SERIAL_SHIFT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         zero_q   <= zero_d;
`ifdef ALU_SERIAL_SHIFT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign ready     = (state_q != StExec);
   assign done      = (state_q == StDone);
   assign aluResult = result_q;
   assign zero      = zero_q;

endmodule

// File: doc/alu_multiciclo.md
ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (at least 8).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request strobe, accepted only when ready=1.
REQ-005 SHALL have port: aluControl  input  3  operation code, sampled on accept.
REQ-006 SHALL have port: srcA  input  WIDTH  operand A, sampled on accept.
REQ-007 SHALL have port: srcB  input  WIDTH  operand B, sampled on accept.
REQ-008 SHALL have port: ready  output  1  block can accept start this cycle.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: aluResult  output  WIDTH  registered result.
REQ-011 SHALL have port: zero  output  1  registered flag, 1 when aluResult == 0.

Function
REQ-012 SHALL decode aluControl as: 000 add, 001 subtract (A-B), 010 and, 011 or, 101 signed set-less-than (result 1 or 0, zero-extended).
REQ-013 SHALL perform add and subtract modulo 2^WIDTH, with carry/borrow discarded.
REQ-014 SHALL implement an FSM with states IDLE, EXEC and DONE; reset state is IDLE.
REQ-015 SHALL go from IDLE to EXEC on start && ready, latching aluControl, srcA and srcB at that edge.
REQ-016 SHALL make basic ops take exactly one EXEC cycle: accept at edge N, done=1 during cycle N+2.
REQ-017 SHALL hold done=1 in DONE for exactly one cycle, then return to IDLE unless a new start is accepted.
REQ-018 SHALL drive ready=1 in IDLE and DONE and ready=0 in EXEC; start in DONE goes directly to EXEC (back-to-back, one result per 2 cycles).
REQ-019 SHALL ignore start while ready=0; operand and opcode changes during EXEC SHALL NOT affect the result.
REQ-020 SHALL update aluResult and zero only on the EXEC-to-DONE transition, holding them stable until the next completion.
REQ-021 SHALL treat undefined codes (110, 111, and 100 when shift is disabled) as result 0 and zero=1, with basic-op latency and no hang.
REQ-022 SHALL compute zero from the full WIDTH-bit result.

Reset
REQ-023 SHALL on reset assertion, at any time including mid-EXEC, force state IDLE, ready=1, done=0, aluResult=0, zero=1 and clear operand/shift registers immediately.
REQ-024 SHALL ignore start in the first rising edge after reset deassertion only when reset is still high at that edge.

Configuration
REQ-025 SHALL, when ALU_SERIAL_SHIFT_EN is defined, decode code 100 as a logical left shift of A by srcB[4:0] (srcB[log2 WIDTH-1:0] if WIDTH is not 32), one bit per EXEC cycle.
REQ-026 SHALL with ALU_SERIAL_SHIFT_EN make EXEC last max(1, shamt) cycles, so done occurs at N+1+max(1, shamt); a shift of 0 returns A.
REQ-027 SHALL, when ALU_SERIAL_SHIFT_EN is undefined, include no shift counter or shift register logic, and treat code 100 per REQ-021.

Structure
REQ-028 SHALL place aluControl code constants and the FSM state typedef in shared package alu_pkg, which alu_deco users also reference.
REQ-029 SHALL instantiate one combinational sub-module alu_core (single-cycle add/sub/and/or/slt); the FSM, operand registers and serial shifter live in alu_multiciclo.

Verification
REQ-030 SHALL verify add: start, code 000, A=0x7FFFFFFF, B=1 -> done at N+2, aluResult=0x80000000, zero=0.
REQ-031 SHALL verify sub wrap: code 001, A=0, B=1 -> aluResult=0xFFFFFFFF; then A=5, B=5 -> aluResult=0, zero=1.
REQ-032 SHALL verify signed slt: code 101, A=0xFFFFFFFF, B=1 -> aluResult=1; swap operands -> aluResult=0.
REQ-033 SHALL verify back-to-back and busy: start in DONE cycle is accepted, and start pulses during EXEC are ignored (exactly one done per accepted start, order preserved).
REQ-034 SHALL verify reset mid-EXEC: reset asserted one cycle after accept -> no done pulse, aluResult=0, zero=1, ready=1 the same cycle.
REQ-035 SHALL verify, with ALU_SERIAL_SHIFT_EN, code 100, A=1, B=31 -> done at N+32, aluResult=0x80000000; and B=0 -> done at N+2, aluResult=1.
